multiply_n_digit: RTL and testbench

//  Sequential unsigned fixed-point multiplier, the inverse companion of the team's
//  n.digit divider: y = a*b with both operands and result in Q(n.digit) format.

---
 rtl/multiply_n_digit.sv | 147 ++++++++++++++
 tb/tb_multiply_n_digit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multiply_n_digit.sv
// -----------------------------------------------------------------------------
// multiply_n_digit
//   Sequential unsigned fixed-point multiplier, y = a*b, with operands and
//   result in Q(n.digit) format.
//   - Shift-add architecture that retires one multiplier bit per clock.
//   - start/done handshake.
//   - Result saturates when the integer part of the product overflows.
//
// Ports
//   clk_i    in   1  clock, all state changes on the rising edge
//   rst_i    in   1  synchronous, active-high reset
//   start_i  in   1  job request, accepted in IDLE or DONE
//   data0_i  in   W  multiplicand, Q(n.digit) unsigned
//   data1_i  in   W  multiplier,   Q(n.digit) unsigned
//   busy_o   out  1  high while a job is running
//   done_o   out  1  one-cycle pulse; y_o/ovf_o are valid from this cycle on
//   y_o      out  W  product, Q(n.digit), truncated or saturated
//   ovf_o    out  1  integer part of the exact product does not fit in n bits
// -----------------------------------------------------------------------------
module multiply_n_digit #(
    parameter  int n     = 32,
    parameter  int digit = 16,
    localparam int W     = n + digit
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] data0_i,
    input  logic [W-1:0] data1_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] y_o,
    output logic         ovf_o
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2*W-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each step
    logic [W-1:0]     mplr_q,  mplr_d;    // multiplier, shifted right each step
    logic [2*W-1:0]   acc_q,   acc_d;     // full-width product accumulator
    logic [CW-1:0]    cnt_q,   cnt_d;     // remaining steps after the current one
    logic [W-1:0]     y_q,     y_d;
    logic             ovf_q,   ovf_d;

    logic             accept;
    logic             last_step;
    logic [2*W-1:0]   acc_sum;
    logic             sum_ovf;

    // A request is only honoured outside RUN; start_i during RUN is ignored.
    assign accept    = start_i && (state_q == IDLE || state_q == DONE);
    assign last_step = (state_q == RUN) && (cnt_q == '0);

    // The accumulator is 2W bits wide, so this sum cannot wrap.
    assign acc_sum = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    // Any set bit above the Q(n.digit) integer field means saturation.
    assign sum_ovf = |acc_sum[2*W-1:W+digit];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output is given a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = start_i ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        ovf_d   = ovf_q;

        if (accept) begin
            // Operands are captured here and never looked at again this job.
            mcand_d = {{W{1'b0}}, data0_i};
            mplr_d  = data1_i;
            acc_d   = '0;
            cnt_d   = CW'(W - 1);
        end else if (state_q == RUN) begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q - 1'b1;
            if (last_step) begin
                // Fraction bits below 'digit' are dropped: round toward zero.
                ovf_d = sum_ovf;
                y_d   = sum_ovf ? {W{1'b1}} : acc_sum[W+digit-1:digit];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy_o = (state_q == RUN);
        done_o = (state_q == DONE);
    end

    assign y_o   = y_q;
    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_multiply_n_digit.sv
// -----------------------------------------------------------------------------
// tb_multiply_n_digit
//   Scoreboard bench for multiply_n_digit at default parameters (W = 48).
//   Expected results are queued when a job is accepted and compared when
//   done_o pulses; the busy duration of each job is also checked.
// -----------------------------------------------------------------------------
module tb_multiply_n_digit;

    localparam int N   = 32;
    localparam int DIG = 16;
    localparam int W   = N + DIG;

    typedef struct packed {
        logic [W-1:0] y;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] data0 = '0;
    logic [W-1:0] data1 = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         ovf;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    int   busy_cnt = 0;

    multiply_n_digit #(.n(N), .digit(DIG)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .data0_i (data0),
        .data1_i (data1),
        .busy_o  (busy),
        .done_o  (done),
        .y_o     (y),
        .ovf_o   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact 2W-bit product, then saturate or truncate.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        exp_t e;
        p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.ovf = |p[2*W-1:W+DIG];
        e.y   = e.ovf ? {W{1'b1}} : p[W+DIG-1:DIG];
        return e;
    endfunction

    // Monitor: scoreboard comparison and busy-length measurement.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("y",        64'(y),        64'(e.y));
                    check("ovf",      64'(ovf),      64'(e.ovf));
                    check("busy_len", 64'(busy_cnt), 64'(W));
                end
                busy_cnt = 0;
            end
        end
    end

    // Drive one job starting in the next cycle; its result is queued at accept.
    task automatic start_job(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        start = 1'b1; data0 = a; data1 = b;
        @(posedge clk); #1;
        start = 1'b0;
        sb_q.push_back(model(a, b));
    endtask

    // Wait (bounded) for the running job to leave RUN, then let the monitor see DONE.
    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < W + 10; i++) begin
            @(posedge clk); #1;
            if (!busy) begin seen = 1; break; end
        end
        if (!seen) check("timeout_done", 64'(0), 64'(1));
        @(negedge clk);
    endtask

    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b);
        start_job(a, b);
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time bound exceeded");
    end

    initial begin
        logic [W-1:0] a, b, q;
        logic [63:0]  num;
        bit           ok;
        int           done_seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_y",    64'(y),    64'(0));
        check("rst_ovf",  64'(ovf),  64'(0));
        rst = 1'b0;

        // 1.5 * 2.0 = 3.0; done is a single-cycle pulse
        run_job(48'h1_8000, 48'h2_0000);
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'(0));
        check("idle_busy",  64'(busy), 64'(0));

        // Truncation toward zero
        run_job(48'h0_0001, 48'h0_0001);
        run_job(48'h0_C000, 48'h0_C000);

        // Saturation, then a clean job clears ovf
        run_job(48'hFFFF_FFFF_0000, 48'h2_0000);
        run_job(48'h1_0000, 48'h1_0000);

        // start held 3 cycles, operands changing during RUN
        @(posedge clk); #1;
        start = 1'b1; data0 = 48'h3_0000; data1 = 48'h0_8000;
        @(posedge clk); #1;
        sb_q.push_back(model(48'h3_0000, 48'h0_8000));
        data0 = 48'h7_7777; data1 = 48'h5_5555;
        @(posedge clk); #1;
        data0 = 48'h1234_5678; data1 = 48'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_busy", 64'(busy), 64'(1));

        // Back-to-back: start during the DONE cycle, no idle cycle in between
        begin
            bit seen = 0;
            for (int i = 0; i < W + 10; i++) begin
                @(posedge clk); #1;
                if (done) begin seen = 1; break; end
            end
            if (!seen) check("timeout_b2b", 64'(0), 64'(1));
        end
        start = 1'b1; data0 = 48'h2_4000; data1 = 48'h0_4000;
        @(posedge clk); #1;
        start = 1'b0;
        sb_q.push_back(model(48'h2_4000, 48'h0_4000));
        check("b2b_busy", 64'(busy), 64'(1));
        wait_done();

        // Reset at edge E20 of a job: outputs clear, no done afterwards
        @(posedge clk); #1;
        start = 1'b1; data0 = 48'h5_0000; data1 = 48'h3_0000;
        @(posedge clk); #1;                 // E0
        start = 1'b0;
        repeat (19) @(posedge clk);         // E1..E19
        #1 rst = 1'b1;
        @(posedge clk); #1;                 // E20
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_y",    64'(y),    64'(0));
        check("midrst_ovf",  64'(ovf),  64'(0));
        done_seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("midrst_quiet", 64'(done_seen), 64'(0));
        run_job(48'h0_C000, 48'h0_C000);

        // Zero operand: full latency, zero result
        run_job(48'h0, 48'h1_2345);
        run_job(48'hABCD_1234_5678, 48'h0);

        // Cross-check against divider results: q = a/b, then q*b must return a
        for (int k = 0; k < 6; k++) begin
            a   = {8'($urandom_range(0, 255)), 32'($urandom)};
            b   = 48'($urandom_range(4096, 32'hFFFF_FFFF));
            num = {a, 16'h0};
            q   = W'(num / 64'(b));
            run_job(q, b);
            ok  = (y <= a) && ((64'(a) - 64'(y)) <= (64'(b) / 64'd65536 + 64'd1));
            check("xchk_bound", 64'(ok), 64'(1));
        end

        repeat (3) @(posedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
